// File: rtl/serial_byte_rx.sv
// Serial-to-byte receiver: assembles WIDTH-bit frames MSB- or LSB-first from a
// qualified bit stream and holds each frame in a one-entry valid/ready buffer.
module serial_byte_rx #(
    parameter int  WIDTH = 8,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sh_r;
    logic             order_r;

    logic [WIDTH-1:0] first_sh_s;
    logic [WIDTH-1:0] next_sh_s;
    logic             last_bit_s;
    logic             consume_s;

    // Candidate shift-register values for a frame start and for a continuing frame.
    always_comb begin
        first_sh_s = '0;
        next_sh_s  = '0;
        if (msb_first) begin
            first_sh_s = {sh_r[WIDTH-2:0], sin};
        end else begin
            first_sh_s = {sin, sh_r[WIDTH-1:1]};
        end
        if (order_r) begin
            next_sh_s = {sh_r[WIDTH-2:0], sin};
        end else begin
            next_sh_s = {sin, sh_r[WIDTH-1:1]};
        end
        last_bit_s = (bit_cnt == CW'(WIDTH - 1));
        consume_s  = q_valid & q_ready;
    end

    // Frame FSM, holding buffer and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            sh_r    <= '0;
            order_r <= 1'b1;
            bit_cnt <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            state_r <= IDLE;
            sh_r    <= '0;
            bit_cnt <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (consume_s) begin
                q_valid <= 1'b0;
            end
            if (sin_valid) begin
                case (state_r)
                    IDLE: begin
                        order_r <= msb_first;
                        sh_r    <= first_sh_s;
                        bit_cnt <= CW'(1);
                        state_r <= SHIFT;
                    end
                    SHIFT: begin
                        if (last_bit_s) begin
                            // Frame done: the register is cleared so no bits leak into the next frame.
                            sh_r    <= '0;
                            bit_cnt <= '0;
                            state_r <= IDLE;
                            if (!q_valid || q_ready) begin
                                q       <= next_sh_s;
                                q_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            sh_r    <= next_sh_s;
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        sh_r    <= '0;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed self-checking bench for serial_byte_rx.
module tb_serial_byte_rx;

    logic       clk;
    logic       reset;
    logic       sin;
    logic       sin_valid;
    logic       msb_first;
    logic       clear;
    logic [7:0] q;
    logic       q_valid;
    logic       q_ready;
    logic       overrun;
    logic [2:0] bit_cnt;

    int n_tests;
    int n_fail;

    serial_byte_rx #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_valid (sin_valid),
        .msb_first (msb_first),
        .clear     (clear),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge; return 1 time unit after the next rising edge.
    task automatic step(input logic v, input logic b, input logic m, input logic rdy, input logic clr);
        @(negedge clk);
        sin_valid = v;
        sin       = b;
        msb_first = m;
        q_ready   = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    // Sends nbits of val; gap_mask[i] inserts two idle cycles before bit i.
    task automatic send_frame(input logic [7:0] val, input logic msb, input int toggle_after,
                              input logic [7:0] gap_mask, input logic rdy_last,
                              input logic clr_last, input int nbits, input logic chk_cnt);
        logic b;
        logic m;
        for (int i = 0; i < nbits; i++) begin
            b = msb ? val[7-i] : val[i];
            m = (toggle_after > 0 && i >= toggle_after) ? ~msb : msb;
            if (gap_mask[i]) begin
                step(1'b0, ~b, ~m, 1'b0, 1'b0);
                step(1'b0, b, m, 1'b0, 1'b0);
                if (chk_cnt) chk("gap_bit_cnt", 32'(bit_cnt), 32'(i % 8));
            end
            step(1'b1, b, m, (i == nbits - 1) ? rdy_last : 1'b0,
                 (i == nbits - 1) ? clr_last : 1'b0);
            if (chk_cnt) chk("bit_cnt", 32'(bit_cnt), 32'((i + 1) % 8));
        end
        @(negedge clk);
        sin_valid = 1'b0;
        q_ready   = 1'b0;
        clear     = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        msb_first = 1'b1;
        clear     = 1'b0;
        q_ready   = 1'b0;
        #3;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // MSB-first 1,1,0,1,0,0,1,1
        send_frame(8'hD3, 1'b1, 0, 8'h00, 1'b0, 1'b0, 8, 1'b1);
        chk("msb_q", 32'(q), 32'hD3);
        chk("msb_q_valid", 32'(q_valid), 32'h1);
        chk("msb_overrun", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("consume_q_valid", 32'(q_valid), 32'h0);
        chk("consume_q_stable", 32'(q), 32'hD3);

        // LSB-first, same bit sequence
        send_frame(8'hCB, 1'b0, 0, 8'h00, 1'b0, 1'b0, 8, 1'b1);
        chk("lsb_q", 32'(q), 32'hCB);
        chk("lsb_q_valid", 32'(q_valid), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hCB, 1'b0, 3, 8'h00, 1'b0, 1'b0, 8, 1'b0);
        chk("lsb_toggle_q", 32'(q), 32'hCB);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Overrun: second frame dropped while buffer full
        send_frame(8'hD3, 1'b1, 0, 8'h00, 1'b0, 1'b0, 8, 1'b0);
        send_frame(8'hA5, 1'b1, 0, 8'h00, 1'b0, 1'b0, 8, 1'b0);
        chk("ovr_q_kept", 32'(q), 32'hD3);
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_q_valid", 32'(q_valid), 32'h1);
        chk("ovr_bit_cnt", 32'(bit_cnt), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovr_consume_q_valid", 32'(q_valid), 32'h0);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clear_overrun", 32'(overrun), 32'h0);
        chk("clear_q_kept", 32'(q), 32'hD3);

        // Completion coincident with consume
        send_frame(8'hD3, 1'b1, 0, 8'h00, 1'b0, 1'b0, 8, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 8'h00, 1'b1, 1'b0, 8, 1'b0);
        chk("sim_q", 32'(q), 32'h3C);
        chk("sim_q_valid", 32'(q_valid), 32'h1);
        chk("sim_overrun", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Async reset mid-frame
        send_frame(8'hFF, 1'b1, 0, 8'h00, 1'b0, 1'b0, 4, 1'b0);
        chk("pre_rst_bit_cnt", 32'(bit_cnt), 32'h4);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_q", 32'(q), 32'h0);
        chk("arst_q_valid", 32'(q_valid), 32'h0);
        chk("arst_overrun", 32'(overrun), 32'h0);
        chk("arst_bit_cnt", 32'(bit_cnt), 32'h0);
        reset = 1'b1;
        send_frame(8'h81, 1'b1, 0, 8'h00, 1'b0, 1'b0, 8, 1'b1);
        chk("post_rst_q", 32'(q), 32'h81);
        chk("post_rst_q_valid", 32'(q_valid), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Gaps inside a frame
        send_frame(8'h5A, 1'b1, 0, 8'b0100_1010, 1'b0, 1'b0, 8, 1'b1);
        chk("gap_q", 32'(q), 32'h5A);
        chk("gap_q_valid", 32'(q_valid), 32'h1);

        // clear on the completing edge wins
        send_frame(8'hF0, 1'b1, 0, 8'h00, 1'b1, 1'b1, 8, 1'b0);
        chk("clr_last_q_valid", 32'(q_valid), 32'h0);
        chk("clr_last_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("clr_last_q_kept", 32'(q), 32'h5A);
        chk("clr_last_overrun", 32'(overrun), 32'h0);
        send_frame(8'h12, 1'b1, 0, 8'h00, 1'b0, 1'b0, 8, 1'b1);
        chk("after_clr_q", 32'(q), 32'h12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_byte_rx.md
Name: serial_byte_rx

Overview:
- Receive-side counterpart of the team's universal shift register used as a parallel-load/shift-out serializer.
- Accepts a qualified serial bit stream, assembles 8-bit frames MSB-first or LSB-first, and presents each byte through a one-entry holding buffer.
- The buffer uses a valid/ready handshake and has a sticky overrun flag.
- Sits between a serial link and byte-wide consumer logic.

Parameters:
- WIDTH, 8, frame/data width in bits; counter width is clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: 0 resets the block immediately, regardless of clk.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this clock edge when 1.
- msb_first  input  1  frame bit order: 1 = first bit is MSB, 0 = first bit is LSB. Latched at frame start.
- clear  input  1  synchronous flush of frame, buffer and overrun.
- q  output  WIDTH  received byte (holding register).
- q_valid  output  1  q holds an unconsumed byte.
- q_ready  input  1  consumer accepts q when q_valid and q_ready are both 1.
- overrun  output  1  sticky: a completed frame was dropped.
- bit_cnt  output  clog2(WIDTH)  bits accepted in the current frame.

Behaviour:
- Reset (reset=0, async): shift reg=0, bit_cnt=0, q=0, q_valid=0, overrun=0, state=IDLE, latched order=1.
- State machine, two states:
  - IDLE: bit_cnt=0. On sin_valid, latch msb_first into the order bit, shift in the first bit, set bit_cnt=1, go to SHIFT.
  - SHIFT: each sin_valid shifts one bit and increments bit_cnt. On the WIDTH-th bit, the frame completes, bit_cnt returns to 0 and the state goes to IDLE.
- Shift rule:
  - order=1: sh <= {sh[WIDTH-2:0], sin} (left shift).
  - order=0: sh <= {sin, sh[WIDTH-1:1]} (right shift).
  - The completed frame value includes the bit shifted in on the completing edge.
- msb_first changes while in SHIFT are ignored until the next frame.
- sin_valid=0: no state change. Gaps of any length between bits are allowed.
- Completion latency: the byte appears on q with q_valid=1 on the clock edge that accepts the last bit, i.e. visible in the following cycle.
- Handshake:
  - Consume = q_valid & q_ready; q_valid falls on the next edge unless a new frame completes on that same edge.
  - q is stable while q_valid=1 and not consumed.
  - q_ready while q_valid=0 has no effect.
- Simultaneous completion and consume: q loads the new byte and q_valid stays 1. No overrun.
- Completion while q_valid=1 and q_ready=0:
  - The new frame is dropped; q keeps the old byte.
  - overrun is set to 1 and the receiver returns to IDLE.
- overrun clears only on reset or clear.
- clear=1 (sync): sh=0, bit_cnt=0, IDLE, q_valid=0, overrun=0; q is left unchanged.
  - clear has priority over sin_valid and over completion on the same edge.
- Reset mid-frame: partial frame discarded; the next bit after release starts a new frame.
- No combinational path from sin/sin_valid to any output; all outputs are registered.

Test Plan:
- Reset, then msb_first=1, bits 1,1,0,1,0,0,1,1 on consecutive cycles, q_ready=0 -> bit_cnt steps 1..7, then 0. The cycle after the 8th bit: q=0xD3, q_valid=1, overrun=0.
- msb_first=0, same bit sequence -> q=0xCB. Toggling msb_first to 1 after bit 3 still gives q=0xCB.
- Hold q_ready=0 with 0xD3 buffered, send a second frame 0xA5 -> q stays 0xD3, overrun=1. Pulse q_ready -> q_valid=0 next cycle. Assert clear -> overrun=0.
- q_ready=1 on the same edge the second frame (0x3C) completes, with 0xD3 buffered -> q=0x3C, q_valid stays 1, overrun=0.
- Send 4 bits, pulse reset low between clock edges -> all outputs 0 immediately. Then 8 bits of 0x81 -> q=0x81, with no trace of the old bits.
- Insert random sin_valid=0 gaps within a 0x5A frame -> q=0x5A. clear on the same edge as the 8th bit -> q_valid=0, bit_cnt=0.
